ufifo_wm: RTL and testbench
===========================

# ufifo_wm

Parametrised successor to the UART byte FIFO: a first-word-fall-through synchronous FIFO with generic width and depth, full-depth storage (all 2^LGFLEN entries usable), a programmable fill watermark, synchronous flush, and sticky overflow/underflow flags with explicit clear. It sits between the UART RX/TX engines and the Wishbone register file. It also serves as the general buffering FIFO elsewhere in the design.

## Interface
- BW, 8: data width in bits, 1..32.
- LGFLEN, 4: log2 of depth; legal range 2..9; FLEN = 2^LGFLEN.
- RXFIFO, 0: 1 means status reports entries held; 0 means status reports free slots.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous empty request.
- i_wr  in  1  write strobe.
- i_data  in  BW  write data.
- i_rd  in  1  read/pop strobe.
- o_data  out  BW  head-of-FIFO data; valid while o_empty_n.
- o_empty_n  out  1  FIFO holds at least one entry.
- o_full  out  1  FIFO holds FLEN entries.
- o_fill  out  LGFLEN+1  entries held, 0..FLEN.
- i_level  in  LGFLEN+1  watermark threshold.
- o_level  out  1  watermark reached.
- i_clr_err  in  1  clears sticky error flags.
- o_ovfl, o_unfl  out  1 each  sticky overflow and underflow flags.
- o_err  out  1  o_ovfl | o_unfl.
- o_status  out  16  {LGFLEN[3:0], count[9:0] zero-extended, o_level, avail}.

## Operation
- Pointers: wr_ptr and rd_ptr are LGFLEN+1 bits wide. The extra MSB separates full from empty. Both wrap modulo 2·FLEN.
- Fill: fill = wr_ptr − rd_ptr. It is held in a register and output as o_fill.
- Write accept: i_wr && (!o_full || i_rd).
- Overflow: i_wr && o_full && !i_rd. The write is dropped, memory is not modified, and o_ovfl is set.
- Read accept: i_rd && o_empty_n.
- Underflow: i_rd && !o_empty_n. Nothing is popped and o_unfl is set. This applies even when i_wr is asserted in the same cycle, because the written data is not yet visible.
- Simultaneous accepted read and write: fill is unchanged and both pointers advance.
- i_flush:
  - Sets rd_ptr to wr_ptr, fill to 0, and o_empty_n to 0.
  - Takes priority over i_wr and i_rd in the same cycle; both are ignored and neither sets an error.
  - Leaves o_ovfl and o_unfl unchanged.
- i_clr_err: clears o_ovfl and o_unfl. A new error in the same cycle wins, so the flag stays set.
- o_level, RXFIFO=1: asserted when fill_next ≥ i_level.
- o_level, RXFIFO=0: asserted when (FLEN − fill_next) ≥ i_level.
- i_level = 0 holds o_level at 1.
- Status count: fill when RXFIFO=1, FLEN − fill when RXFIFO=0.
- Status avail: o_empty_n when RXFIFO=1, !o_full when RXFIFO=0.

## Timing
- Reset values:
  - o_empty_n=0, o_full=0, o_fill=0, o_ovfl=0, o_unfl=0, o_data=0.
  - o_level = (i_level==0) for RXFIFO=1; o_level = (FLEN ≥ i_level) for RXFIFO=0.
- All outputs are registered. o_level is an exception only in that it reflects i_level changes one cycle later.
- Write latency: a write accepted at edge N into an empty FIFO gives o_empty_n=1 and o_data=i_data after edge N. This uses a bypass path, not a memory re-read.
- Read latency: a read accepted at edge N with fill ≥ 2 presents the next entry on o_data after edge N. With fill = 1, o_empty_n=0 after edge N and o_data holds its last value.
- Flags track fill: o_full, o_fill, o_level and o_empty_n all update on the same edge as the pointer change.
- Wrap-around: no bubble or stall at the pointer wrap, and sustained read+write runs at one word per cycle.
- Mid-operation reset: an asynchronous i_rst assertion forces the reset values immediately. Memory contents are not cleared and are don't-care.

## Structure
- Shared package/include ufifo_defs holds:
  - status field positions (LGLEN [15:12], COUNT [11:2], LEVEL [1], AVAIL [0]);
  - the LGFLEN legal range.
- One sub-module, ufifo_mem: simple dual-port RAM, BW×FLEN, one synchronous write port and one synchronous read port, no reset. It stays inferable as block or distributed RAM.
- Control, pointers, bypass register and flags live in ufifo_wm.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on three consecutive cycles:
  - o_empty_n=1 and o_data=0x11 one cycle after the first write;
  - o_fill=3 after the third.
- Fill to full, using LGFLEN=4 and RXFIFO=0:
  - 16 writes give o_full=1 and status count=0;
  - a 17th write alone sets o_ovfl=1 and o_err=1, with data unchanged;
  - read+write while full keeps o_fill=16 and o_ovfl unchanged.
- Empty read: i_rd with i_wr=1 on an empty FIFO → o_unfl=1, o_fill=1, o_data = the written word. Then i_clr_err → both flags 0 on the next cycle.
- Watermark, RXFIFO=1, i_level=5: o_level rises on the edge where o_fill reaches 5. It falls on the edge where a read makes o_fill 4.
- Wrap: 1000 cycles of random read/write with random data against a reference queue. o_data, o_fill and the flags match every cycle, and at least 4 pointer wraps occur.
- Flush and async reset:
  - i_flush with 7 entries plus i_wr=1 → o_fill=0, o_empty_n=0, no error;
  - i_rst pulsed between clock edges mid-stream → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/ufifo_wm_pkg.sv
// ufifo_defs: shared definitions for the ufifo_wm FIFO family.
//   - bit positions of the 16-bit status word
//   - legal parameter ranges
//   - watermark comparison helper shared by every FIFO instance
package ufifo_defs;

  // Status word layout: {LGLEN[15:12], COUNT[11:2], LEVEL[1], AVAIL[0]}
  localparam int STAT_LGLEN_HI = 15;
  localparam int STAT_LGLEN_LO = 12;
  localparam int STAT_COUNT_HI = 11;
  localparam int STAT_COUNT_LO = 2;
  localparam int STAT_LEVEL    = 1;
  localparam int STAT_AVAIL    = 0;

  // Legal parameter ranges
  localparam int LGFLEN_MIN = 2;
  localparam int LGFLEN_MAX = 9;
  localparam int BW_MIN     = 1;
  localparam int BW_MAX     = 32;

  // Watermark: an RX FIFO compares entries held against the threshold,
  // a TX FIFO compares free slots. A zero threshold is always reached.
  function automatic logic level_hit(input int fill, input int thr,
                                     input bit rxfifo, input int flen);
    if (rxfifo) return fill >= thr;
    return (flen - fill) >= thr;
  endfunction

endpackage

// File: rtl/ufifo_wm_if.sv
// ufifo_wm_if: FIFO data/control/status bundle.
//   master : the client (UART engine or register file) driving i_* signals
//   slave  : the FIFO itself, driving o_* signals
// Signal names follow the FIFO's point of view (i_* into the FIFO).
interface ufifo_wm_if #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
);
  logic              i_flush;
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              i_rd;
  logic [LGFLEN:0]   i_level;
  logic              i_clr_err;
  logic [BW-1:0]     o_data;
  logic              o_empty_n;
  logic              o_full;
  logic [LGFLEN:0]   o_fill;
  logic              o_level;
  logic              o_ovfl;
  logic              o_unfl;
  logic              o_err;
  logic [15:0]       o_status;

  modport master (
    output i_flush, i_wr, i_data, i_rd, i_level, i_clr_err,
    input  o_data, o_empty_n, o_full, o_fill, o_level, o_ovfl, o_unfl,
           o_err, o_status
  );

  modport slave (
    input  i_flush, i_wr, i_data, i_rd, i_level, i_clr_err,
    output o_data, o_empty_n, o_full, o_fill, o_level, o_ovfl, o_unfl,
           o_err, o_status
  );
endinterface

// File: rtl/ufifo_mem.sv
// ufifo_mem: simple dual-port RAM, BW x 2^LGFLEN.
//   i_clk   : clock
//   wr_en   : write enable, wr_addr / wr_data : write port
//   rd_addr : read address, rd_data : registered read data (old data on
//             a same-address write; the caller bypasses that case)
module ufifo_mem #(
  parameter int BW     = 8,
  parameter int LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [LGFLEN-1:0] wr_addr,
  input  logic [BW-1:0]     wr_data,
  input  logic [LGFLEN-1:0] rd_addr,
  output logic [BW-1:0]     rd_data
);

  logic [BW-1:0] mem [2**LGFLEN];

  // NOTE: storage has no reset so it maps onto block or distributed RAM;
  // the control logic never presents an unwritten entry as valid.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ufifo_wm.sv
// ufifo_wm: first-word-fall-through synchronous FIFO with watermark.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   bus    : ufifo_wm_if.slave -- write/read strobes, flush, watermark
//            threshold, error clear in; head data, empty/full, fill,
//            watermark, sticky overflow/underflow and status word out
// Parameters: BW data width, LGFLEN log2 depth (all 2^LGFLEN entries
// usable), RXFIFO selects entries-held (1) or free-slots (0) reporting.
module ufifo_wm
  import ufifo_defs::*;
#(
  parameter int BW     = 8,
  parameter int LGFLEN = 4,
  parameter bit RXFIFO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  ufifo_wm_if.slave   bus
);

  localparam int              FLEN   = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FLEN_W = (LGFLEN+1)'(FLEN);

  if (LGFLEN < LGFLEN_MIN || LGFLEN > LGFLEN_MAX) begin : g_bad_lgflen
    $error("ufifo_wm: LGFLEN out of range");
  end
  if (BW < BW_MIN || BW > BW_MAX) begin : g_bad_bw
    $error("ufifo_wm: BW out of range");
  end

  // Pointers carry one extra MSB so a full FIFO differs from an empty one.
  logic [LGFLEN:0] wr_ptr, rd_ptr, fill;
  logic [LGFLEN:0] wr_ptr_nxt, rd_ptr_nxt, fill_nxt;
  logic            empty_n, full, level, ovfl, unfl;
  logic            wr_ok, rd_ok, ovfl_set, unfl_set, head_is_new;
  logic            sel_bypass;
  logic [BW-1:0]   bypass_data, ram_data, data_out;
  logic [LGFLEN:0] count;
  logic [15:0]     status;

  // NOTE: every signal assigned here gets a value on every path, so no
  // latch can be inferred.
  always_comb begin
    wr_ok    = bus.i_wr && (!full || bus.i_rd) && !bus.i_flush;
    rd_ok    = bus.i_rd && empty_n && !bus.i_flush;
    ovfl_set = bus.i_wr && full && !bus.i_rd && !bus.i_flush;
    // A same-cycle write cannot satisfy a read of an empty FIFO.
    unfl_set = bus.i_rd && !empty_n && !bus.i_flush;

    wr_ptr_nxt = wr_ptr + (LGFLEN+1)'(wr_ok);
    rd_ptr_nxt = bus.i_flush ? wr_ptr : rd_ptr + (LGFLEN+1)'(rd_ok);
    fill_nxt   = wr_ptr_nxt - rd_ptr_nxt;

    // The slot being written becomes the head only when it is the sole
    // entry after this edge; the RAM would return stale data for it.
    head_is_new = wr_ok && (wr_ptr[LGFLEN-1:0] == rd_ptr_nxt[LGFLEN-1:0]);
  end

  // The RAM always reads the head-to-be, so the next head is ready one
  // edge later with no bubble at pointer wrap.
  ufifo_mem #(.BW(BW), .LGFLEN(LGFLEN)) u_mem (
    .i_clk   (i_clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[LGFLEN-1:0]),
    .wr_data (bus.i_data),
    .rd_addr (rd_ptr_nxt[LGFLEN-1:0]),
    .rd_data (ram_data)
  );

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      empty_n     <= 1'b0;
      full        <= 1'b0;
      ovfl        <= 1'b0;
      unfl        <= 1'b0;
      sel_bypass  <= 1'b1;
      bypass_data <= '0;
      // Reset value follows the threshold as seen with an empty FIFO.
      level       <= level_hit(0, int'(bus.i_level), RXFIFO, FLEN);
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      fill    <= fill_nxt;
      empty_n <= (fill_nxt != '0);
      full    <= (fill_nxt == FLEN_W);
      level   <= level_hit(int'(fill_nxt), int'(bus.i_level), RXFIFO, FLEN);
      ovfl    <= ovfl_set || (ovfl && !bus.i_clr_err);
      unfl    <= unfl_set || (unfl && !bus.i_clr_err);

      if (fill_nxt == '0) begin
        // Going (or staying) empty: freeze the last head value.
        sel_bypass  <= 1'b1;
        bypass_data <= data_out;
      end else if (head_is_new) begin
        sel_bypass  <= 1'b1;
        bypass_data <= bus.i_data;
      end else begin
        sel_bypass  <= 1'b0;
      end
    end
  end

  assign data_out = sel_bypass ? bypass_data : ram_data;
  assign count    = RXFIFO ? fill : FLEN_W - fill;

  always_comb begin
    status = '0;
    status[STAT_LGLEN_HI:STAT_LGLEN_LO] = 4'(LGFLEN);
    status[STAT_COUNT_HI:STAT_COUNT_LO] = 10'(count);
    status[STAT_LEVEL]                  = level;
    status[STAT_AVAIL]                  = RXFIFO ? empty_n : !full;
  end

  assign bus.o_data    = data_out;
  assign bus.o_empty_n = empty_n;
  assign bus.o_full    = full;
  assign bus.o_fill    = fill;
  assign bus.o_level   = level;
  assign bus.o_ovfl    = ovfl;
  assign bus.o_unfl    = unfl;
  assign bus.o_err     = ovfl | unfl;
  assign bus.o_status  = status;

endmodule

// File: tb/tb_ufifo_wm.sv
// tb_ufifo_wm: self-checking bench for ufifo_wm. Two instances (free-slot
// and entries-held reporting) share one stimulus stream and are compared
// against a queue-based reference model after every clock edge.
module tb_ufifo_wm;

  localparam int BW   = 8;
  localparam int LG   = 4;
  localparam int FLEN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [BW-1:0] data = '0;
  logic [LG:0]   level = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ufifo_wm_if #(.BW(BW), .LGFLEN(LG)) if0 ();
  ufifo_wm_if #(.BW(BW), .LGFLEN(LG)) if1 ();

  assign if0.i_flush = flush;  assign if1.i_flush = flush;
  assign if0.i_wr    = wr;     assign if1.i_wr    = wr;
  assign if0.i_data  = data;   assign if1.i_data  = data;
  assign if0.i_rd    = rd;     assign if1.i_rd    = rd;
  assign if0.i_level = level;  assign if1.i_level = level;
  assign if0.i_clr_err = clr;  assign if1.i_clr_err = clr;

  ufifo_wm #(.BW(BW), .LGFLEN(LG), .RXFIFO(1'b0)) dut0 (
    .i_clk (clk), .i_rst (rst), .bus (if0.slave));
  ufifo_wm #(.BW(BW), .LGFLEN(LG), .RXFIFO(1'b1)) dut1 (
    .i_clk (clk), .i_rst (rst), .bus (if1.slave));

  // Full observable snapshot of each instance
  logic [34:0] act0, act1;
  assign act0 = {if0.o_data, if0.o_empty_n, if0.o_full, if0.o_fill, if0.o_ovfl,
                 if0.o_unfl, if0.o_err, if0.o_level, if0.o_status};
  assign act1 = {if1.o_data, if1.o_empty_n, if1.o_full, if1.o_fill, if1.o_ovfl,
                 if1.o_unfl, if1.o_err, if1.o_level, if1.o_status};

  // ---------------- reference model ----------------
  logic [BW-1:0] q[$];
  logic [BW-1:0] m_data;
  bit            m_ovfl, m_unfl, m_lvl0, m_lvl1;
  int            pushes;

  function automatic void model_levels();
    m_lvl1 = (q.size() >= int'(level));
    m_lvl0 = ((FLEN - q.size()) >= int'(level));
  endfunction

  function automatic void model_reset();
    q.delete();
    m_data = '0;
    m_ovfl = 0;
    m_unfl = 0;
    model_levels();
  endfunction

  // One clock edge of FIFO behaviour using the inputs present at the edge.
  function automatic void model_step();
    int  n  = q.size();
    bit  ov = 0, un = 0;
    if (flush) begin
      q.delete();
    end else begin
      if (rd && n > 0) void'(q.pop_front());
      if (rd && n == 0) un = 1;
      if (wr && (n < FLEN || rd)) begin
        q.push_back(data);
        pushes++;
      end else if (wr) begin
        ov = 1;
      end
    end
    m_ovfl = ov || (m_ovfl && !clr);
    m_unfl = un || (m_unfl && !clr);
    if (q.size() > 0) m_data = q[0];
    model_levels();
  endfunction

  function automatic logic [34:0] exp_vec(input bit rx);
    int   n   = q.size();
    logic lv  = rx ? m_lvl1 : m_lvl0;
    int   cnt = rx ? n : FLEN - n;
    logic av  = rx ? (n > 0) : (n < FLEN);
    return {m_data, n > 0, n == FLEN, 5'(n), m_ovfl, m_unfl, m_ovfl | m_unfl,
            lv, 4'(LG), 10'(cnt), lv, av};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    level = 5'd5;
    #1 rst = 1'b1;
    #2;
    model_reset();
    checks++;
    if (act0 !== exp_vec(1'b0)) begin
      errors++; $display("FAIL reset_rx0: got %h expected %h", act0, exp_vec(1'b0));
    end
    checks++;
    if (act1 !== exp_vec(1'b1)) begin
      errors++; $display("FAIL reset_rx1: got %h expected %h", act1, exp_vec(1'b1));
    end
    checks++;
    if (if1.o_level !== 1'b0 || if0.o_level !== 1'b1) begin
      errors++; $display("FAIL reset_level: got rx1=%b rx0=%b expected rx1=0 rx0=1",
                         if1.o_level, if0.o_level);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_write_seq();
    wr = 1; data = 8'h11; tick();
    checks++;
    if (if1.o_empty_n !== 1'b1 || if1.o_data !== 8'h11) begin
      errors++; $display("FAIL first_write: got empty_n=%b data=%h expected 1 11",
                         if1.o_empty_n, if1.o_data);
    end
    data = 8'h22; tick();
    data = 8'h33; tick();
    wr = 0;
    checks++;
    if (if1.o_fill !== 5'd3 || if1.o_data !== 8'h11) begin
      errors++; $display("FAIL three_writes: got fill=%0d data=%h expected 3 11",
                         if1.o_fill, if1.o_data);
    end
    checks++;
    if (act0 !== exp_vec(1'b0)) begin
      errors++; $display("FAIL write_seq_rx0: got %h expected %h", act0, exp_vec(1'b0));
    end
  endtask

  task automatic test_full();
    flush = 1; tick(); flush = 0;
    clr = 1; tick(); clr = 0;
    wr = 1;
    for (int i = 0; i < FLEN; i++) begin
      data = 8'($urandom);
      tick();
    end
    checks++;
    if (if0.o_full !== 1'b1 || if0.o_status[11:2] !== 10'd0) begin
      errors++; $display("FAIL full: got full=%b count=%0d expected 1 0",
                         if0.o_full, if0.o_status[11:2]);
    end
    data = 8'hEE; tick();
    checks++;
    if (if0.o_ovfl !== 1'b1 || if0.o_err !== 1'b1 || if0.o_fill !== 5'd16 ||
        if0.o_data !== q[0]) begin
      errors++; $display("FAIL overflow: got ovfl=%b err=%b fill=%0d data=%h expected 1 1 16 %h",
                         if0.o_ovfl, if0.o_err, if0.o_fill, if0.o_data, q[0]);
    end
    rd = 1; data = 8'h5C; tick();
    checks++;
    if (if0.o_fill !== 5'd16 || if0.o_ovfl !== 1'b1 || if0.o_data !== q[0]) begin
      errors++; $display("FAIL rdwr_full: got fill=%0d ovfl=%b data=%h expected 16 1 %h",
                         if0.o_fill, if0.o_ovfl, if0.o_data, q[0]);
    end
    wr = 0;
    for (int i = 0; i < FLEN; i++) begin
      tick();
      checks++;
      if (act0 !== exp_vec(1'b0)) begin
        errors++; $display("FAIL drain_%0d: got %h expected %h", i, act0, exp_vec(1'b0));
      end
    end
    rd = 0;
  endtask

  task automatic test_empty_read();
    clr = 1; tick(); clr = 0;
    rd = 1; wr = 1; data = 8'hA5; tick();
    rd = 0; wr = 0;
    checks++;
    if (if1.o_unfl !== 1'b1 || if1.o_fill !== 5'd1 || if1.o_data !== 8'hA5) begin
      errors++; $display("FAIL empty_read: got unfl=%b fill=%0d data=%h expected 1 1 a5",
                         if1.o_unfl, if1.o_fill, if1.o_data);
    end
    clr = 1; tick(); clr = 0;
    checks++;
    if (if1.o_unfl !== 1'b0 || if1.o_ovfl !== 1'b0 || if1.o_err !== 1'b0) begin
      errors++; $display("FAIL clr_err: got unfl=%b ovfl=%b err=%b expected 0 0 0",
                         if1.o_unfl, if1.o_ovfl, if1.o_err);
    end
    rd = 1; tick(); rd = 0;
  endtask

  task automatic test_watermark();
    level = 5'd5; tick();
    wr = 1;
    for (int i = 1; i <= 7; i++) begin
      data = 8'(i); tick();
      checks++;
      if (if1.o_level !== (i >= 5) || if1.o_fill !== 5'(i)) begin
        errors++; $display("FAIL wm_rise_%0d: got level=%b fill=%0d expected %b %0d",
                           i, if1.o_level, if1.o_fill, i >= 5, i);
      end
    end
    wr = 0; rd = 1;
    for (int i = 6; i >= 4; i--) begin
      tick();
      checks++;
      if (if1.o_level !== (i >= 5) || if1.o_fill !== 5'(i)) begin
        errors++; $display("FAIL wm_fall_%0d: got level=%b fill=%0d expected %b %0d",
                           i, if1.o_level, if1.o_fill, i >= 5, i);
      end
    end
    for (int i = 0; i < 4; i++) tick();
    rd = 0;
  endtask

  task automatic test_flush();
    wr = 1;
    for (int i = 0; i < 7; i++) begin data = 8'($urandom); tick(); end
    flush = 1; data = 8'h77; tick();
    flush = 0; wr = 0;
    checks++;
    if (if1.o_fill !== 5'd0 || if1.o_empty_n !== 1'b0 || if1.o_err !== 1'b0 ||
        if0.o_fill !== 5'd0) begin
      errors++; $display("FAIL flush: got fill=%0d empty_n=%b err=%b expected 0 0 0",
                         if1.o_fill, if1.o_empty_n, if1.o_err);
    end
    checks++;
    if (act1 !== exp_vec(1'b1)) begin
      errors++; $display("FAIL flush_snapshot: got %h expected %h", act1, exp_vec(1'b1));
    end
  endtask

  task automatic test_random();
    int start_push = pushes;
    int wr_pct, rd_pct;
    for (int i = 0; i < 1000; i++) begin
      wr_pct = (i < 300) ? 75 : (i < 700) ? 50 : 30;
      rd_pct = (i < 300) ? 30 : (i < 700) ? 50 : 70;
      wr    = ($urandom_range(99) < wr_pct);
      rd    = ($urandom_range(99) < rd_pct);
      flush = ($urandom_range(99) == 0);
      clr   = ($urandom_range(99) < 5);
      data  = 8'($urandom);
      if ($urandom_range(99) < 5) level = 5'($urandom_range(FLEN));
      tick();
      checks++;
      if (act0 !== exp_vec(1'b0)) begin
        errors++; $display("FAIL rand_rx0 cycle %0d: got %h expected %h", i, act0, exp_vec(1'b0));
      end
      checks++;
      if (act1 !== exp_vec(1'b1)) begin
        errors++; $display("FAIL rand_rx1 cycle %0d: got %h expected %h", i, act1, exp_vec(1'b1));
      end
    end
    wr = 0; rd = 0; flush = 0; clr = 0;
    checks++;
    if ((pushes - start_push) / FLEN < 4) begin
      errors++; $display("FAIL wraps: got %0d expected >= 4", (pushes - start_push) / FLEN);
    end
  endtask

  task automatic test_async_reset();
    wr = 1;
    for (int i = 0; i < 5; i++) begin data = 8'($urandom); tick(); end
    #1 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (act0 !== exp_vec(1'b0) || if0.o_fill !== 5'd0 || if0.o_data !== 8'h00) begin
      errors++; $display("FAIL async_rst_rx0: got %h expected %h", act0, exp_vec(1'b0));
    end
    checks++;
    if (act1 !== exp_vec(1'b1) || if1.o_empty_n !== 1'b0) begin
      errors++; $display("FAIL async_rst_rx1: got %h expected %h", act1, exp_vec(1'b1));
    end
    #1 rst = 1'b0;
    data = 8'h3C; tick();
    wr = 0;
    checks++;
    if (if1.o_data !== 8'h3C || if1.o_fill !== 5'd1) begin
      errors++; $display("FAIL post_reset_write: got data=%h fill=%0d expected 3c 1",
                         if1.o_data, if1.o_fill);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pushes = 0;
    test_reset();
    test_write_seq();
    test_full();
    test_empty_read();
    test_watermark();
    test_flush();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
